// File: rtl/sprite_scan_ctrl.sv
// Sprite scan controller: raster counters, bounce motion FSM and sprite ROM read sequencing.
// Latency: rom_addr_o/rom_en_o one cen after the counters, pix_valid_o a further ROM_LAT cen.
// Backpressure: none; all state advances only when cen_i=1 and holds otherwise.
module sprite_scan_ctrl #(
  parameter int SPR_W   = 160,
  parameter int SPR_H   = 120,
  parameter int SCR_W   = 1920,
  parameter int SCR_H   = 1080,
  parameter int STEP    = 2,
  parameter int ROM_LAT = 1,
  parameter int ADDR_W  = 15
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cen_i,
  input  logic [1:0]        vh_blank_i,
  input  logic              move_en_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  output logic              rom_en_o,
  output logic              pix_valid_o,
  output logic [11:0]       pos_x_o,
  output logic [11:0]       pos_y_o,
  output logic [11:0]       hcount_o,
  output logic [11:0]       vcount_o,
  output logic              frame_tick_o
);

  localparam logic [11:0] POS_X0  = 12'((SCR_W - SPR_W) / 2);
  localparam logic [11:0] POS_Y0  = 12'((SCR_H - SPR_H) / 2);
  localparam logic [11:0] LIM_X   = 12'(SCR_W - SPR_W);
  localparam logic [11:0] LIM_Y   = 12'(SCR_H - SPR_H);
  localparam logic [12:0] LIM_X13 = 13'(SCR_W - SPR_W);
  localparam logic [12:0] LIM_Y13 = 13'(SCR_H - SPR_H);
  localparam logic [12:0] SPR_W13 = 13'(SPR_W);
  localparam logic [12:0] SPR_H13 = 13'(SPR_H);
  localparam logic [12:0] STEP13  = 13'(STEP);
  localparam logic [11:0] STEP12  = 12'(STEP);
  localparam logic [ADDR_W-1:0] ROW_INC = ADDR_W'(SPR_W);

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_UPDATE = 2'd2,
    ST_BLANK  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic hb, vb, hb_q, vb_q;
  logic h_rise, h_fall, v_rise, v_fall;
  logic in_x, in_y, inwin;
  logic [ADDR_W-1:0] row_base;
  logic dir_x_neg, dir_y_neg, dir_x_neg_nxt, dir_y_neg_nxt;
  logic [11:0] pos_x_nxt, pos_y_nxt;
  logic [ROM_LAT-1:0] pv_sr;

  assign hb     = vh_blank_i[0];
  assign vb     = vh_blank_i[1];
  assign h_rise = hb & ~hb_q;
  assign h_fall = ~hb & hb_q;
  assign v_rise = vb & ~vb_q;
  assign v_fall = ~vb & vb_q;

  // Sprite window test; upper bounds are summed at 13 bits so they cannot wrap.
  assign in_x  = (hcount_o >= pos_x_o) && ({1'b0, hcount_o} < ({1'b0, pos_x_o} + SPR_W13));
  assign in_y  = (vcount_o >= pos_y_o) && ({1'b0, vcount_o} < ({1'b0, pos_y_o} + SPR_H13));
  assign inwin = (state == ST_ACTIVE) && !hb && !vb && in_x && in_y;

  assign pix_valid_o = pv_sr[ROM_LAT-1];

  // Blank edge history plus pixel/line counters and the incremental row base.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hb_q     <= 1'b0;
      vb_q     <= 1'b0;
      hcount_o <= '0;
      vcount_o <= '0;
      row_base <= '0;
    end else if (cen_i) begin
      hb_q <= hb;
      vb_q <= vb;
      if (h_fall)   hcount_o <= '0;
      else if (!hb) hcount_o <= hcount_o + 12'd1;
      if (v_fall)              vcount_o <= '0;
      else if (h_rise && !vb)  vcount_o <= vcount_o + 12'd1;
      if (v_fall)              row_base <= '0;
      else if (h_rise && in_y) row_base <= row_base + ROW_INC;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i)      state <= ST_SYNC;
    else if (cen_i) state <= state_nxt;
  end

  // FSM next state; the frame tick is high for the single cen cycle spent in UPDATE.
  always_comb begin
    state_nxt    = state;
    frame_tick_o = 1'b0;
    case (state)
      ST_SYNC:   if (v_fall) state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (v_rise) state_nxt = ST_UPDATE;
      ST_UPDATE: begin
        frame_tick_o = 1'b1;
        state_nxt    = ST_BLANK;
      end
      ST_BLANK:  if (v_fall) state_nxt = ST_ACTIVE;
      default:   state_nxt = ST_SYNC;
    endcase
  end

  // Bounce motion candidate: clamp to the exact edge and reverse direction there.
  always_comb begin
    pos_x_nxt     = pos_x_o;
    dir_x_neg_nxt = dir_x_neg;
    pos_y_nxt     = pos_y_o;
    dir_y_neg_nxt = dir_y_neg;
    if (!dir_x_neg) begin
      if (({1'b0, pos_x_o} + STEP13) >= LIM_X13) begin
        pos_x_nxt     = LIM_X;
        dir_x_neg_nxt = 1'b1;
      end else begin
        pos_x_nxt = pos_x_o + STEP12;
      end
    end else begin
      if (pos_x_o <= STEP12) begin
        pos_x_nxt     = '0;
        dir_x_neg_nxt = 1'b0;
      end else begin
        pos_x_nxt = pos_x_o - STEP12;
      end
    end
    if (!dir_y_neg) begin
      if (({1'b0, pos_y_o} + STEP13) >= LIM_Y13) begin
        pos_y_nxt     = LIM_Y;
        dir_y_neg_nxt = 1'b1;
      end else begin
        pos_y_nxt = pos_y_o + STEP12;
      end
    end else begin
      if (pos_y_o <= STEP12) begin
        pos_y_nxt     = '0;
        dir_y_neg_nxt = 1'b0;
      end else begin
        pos_y_nxt = pos_y_o - STEP12;
      end
    end
  end

  // Position only changes in UPDATE, which sits inside vertical blank, so no tearing.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pos_x_o   <= POS_X0;
      pos_y_o   <= POS_Y0;
      dir_x_neg <= 1'b0;
      dir_y_neg <= 1'b0;
    end else if (cen_i && (state == ST_UPDATE) && move_en_i) begin
      pos_x_o   <= pos_x_nxt;
      pos_y_o   <= pos_y_nxt;
      dir_x_neg <= dir_x_neg_nxt;
      dir_y_neg <= dir_y_neg_nxt;
    end
  end

  // ROM request stage: address is row base plus column offset inside the sprite.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rom_en_o   <= 1'b0;
      rom_addr_o <= '0;
    end else if (cen_i) begin
      rom_en_o   <= inwin;
      rom_addr_o <= inwin ? (row_base + ADDR_W'(hcount_o - pos_x_o)) : '0;
    end
  end

  // Delay rom_en_o by the ROM read latency so pix_valid_o lines up with ROM data.
  always_ff @(posedge clk_i) begin
    if (rst_i)      pv_sr <= '0;
    else if (cen_i) pv_sr <= (pv_sr << 1) | ROM_LAT'(rom_en_o);
  end

endmodule

// File: tb/tb_sprite_scan_ctrl.sv
// Randomized raster bench for sprite_scan_ctrl on a reduced screen.
// Driver pushes expected ROM requests, pixel-valid slots and frame ticks into queues.
// A monitor pops and compares whenever the DUT presents an output on a cen cycle.
module tb_sprite_scan_ctrl;
  localparam int SPR_W   = 8;
  localparam int SPR_H   = 6;
  localparam int SCR_W   = 32;
  localparam int SCR_H   = 20;
  localparam int STEP    = 2;
  localparam int ROM_LAT = 2;
  localparam int ADDR_W  = 6;
  localparam int LX      = SCR_W - SPR_W;
  localparam int LY      = SCR_H - SPR_H;
  localparam int PX0     = LX / 2;
  localparam int PY0     = LY / 2;

  logic              clk = 1'b1;
  logic              rst_i;
  logic              cen_i;
  logic [1:0]        vh_blank_i;
  logic              move_en_i;
  logic [ADDR_W-1:0] rom_addr_o;
  logic              rom_en_o;
  logic              pix_valid_o;
  logic [11:0]       pos_x_o, pos_y_o, hcount_o, vcount_o;
  logic              frame_tick_o;

  always #5 clk = ~clk;

  sprite_scan_ctrl #(
    .SPR_W(SPR_W), .SPR_H(SPR_H), .SCR_W(SCR_W), .SCR_H(SCR_H),
    .STEP(STEP), .ROM_LAT(ROM_LAT), .ADDR_W(ADDR_W)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .cen_i(cen_i), .vh_blank_i(vh_blank_i),
    .move_en_i(move_en_i), .rom_addr_o(rom_addr_o), .rom_en_o(rom_en_o),
    .pix_valid_o(pix_valid_o), .pos_x_o(pos_x_o), .pos_y_o(pos_y_o),
    .hcount_o(hcount_o), .vcount_o(vcount_o), .frame_tick_o(frame_tick_o)
  );

  typedef struct { int step; int addr; } rom_exp_t;
  typedef struct { int step; int px; int py; } tick_exp_t;

  rom_exp_t  rom_q[$];
  int        pv_q[$];
  tick_exp_t tick_q[$];

  int checks = 0;
  int errors = 0;
  int drv_step = 0;
  int mon_step = 0;
  int gap_mode = 0;

  bit pend_vld = 0;
  int pend_step, pend_px, pend_py;

  // reference model: pixel/line indices, frame phase and sprite kinematics
  int m_h, m_v, m_px, m_py, m_dx, m_dy, m_npx, m_npy, m_ndx, m_ndy;
  bit m_hbp, m_vbp, m_active, m_upd;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (step %0d)", nm, act, exp, mon_step);
    end
  endtask

  task automatic model_reset();
    m_h = 0; m_v = 0; m_hbp = 0; m_vbp = 0;
    m_active = 0; m_upd = 0;
    m_px = PX0; m_py = PY0; m_dx = 1; m_dy = 1;
    rom_q.delete(); pv_q.delete(); tick_q.delete();
    pend_vld = 0;
  endtask

  task automatic model_step(input bit hb, input bit vb);
    bit hr, hf, vr, vf;
    rom_exp_t e;
    tick_exp_t t;
    hr = hb && !m_hbp;  hf = !hb && m_hbp;
    vr = vb && !m_vbp;  vf = !vb && m_vbp;
    if (m_active && !hb && !vb &&
        m_h >= m_px && m_h < m_px + SPR_W && m_v >= m_py && m_v < m_py + SPR_H) begin
      e.step = drv_step;
      e.addr = (m_v - m_py) * SPR_W + (m_h - m_px);
      rom_q.push_back(e);
      pv_q.push_back(drv_step);
    end
    if (m_upd) begin
      m_upd = 0;
      m_px = m_npx; m_py = m_npy; m_dx = m_ndx; m_dy = m_ndy;
    end else if (vr && m_active) begin
      m_active = 0;
      m_upd = 1;
      m_npx = m_px; m_npy = m_py; m_ndx = m_dx; m_ndy = m_dy;
      if (move_en_i) begin
        m_npx = m_px + m_dx * STEP;
        if (m_npx >= LX) begin m_npx = LX; m_ndx = -1; end
        else if (m_npx <= 0) begin m_npx = 0; m_ndx = 1; end
        m_npy = m_py + m_dy * STEP;
        if (m_npy >= LY) begin m_npy = LY; m_ndy = -1; end
        else if (m_npy <= 0) begin m_npy = 0; m_ndy = 1; end
      end
      t.step = drv_step; t.px = m_npx; t.py = m_npy;
      tick_q.push_back(t);
    end else if (vf) begin
      m_active = 1;
    end
    if (hf) m_h = 0;
    else if (!hb) m_h++;
    if (vf) m_v = 0;
    else if (hr && !vb) m_v++;
    m_hbp = hb;
    m_vbp = vb;
  endtask

  task automatic cyc(input bit c, input bit r, input logic [1:0] vh);
    @(negedge clk);
    cen_i = c;
    rst_i = r;
    vh_blank_i = vh;
    if (c) drv_step++;
    if (r) model_reset();
    else if (c) model_step(vh[0], vh[1]);
  endtask

  task automatic pix(input logic [1:0] vh, input bit r);
    int g;
    g = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
    repeat (g) cyc(1'b0, 1'b0, vh);
    cyc(1'b1, r, vh);
    if (r) begin
      @(posedge clk); #2;
      chk("midreset_rom_en", int'(rom_en_o), 0);
      chk("midreset_pos_x", int'(pos_x_o), PX0);
      chk("midreset_pos_y", int'(pos_y_o), PY0);
    end
  endtask

  task automatic line(input bit vb, input int rc);
    int hbl;
    hbl = $urandom_range(2, 4);
    for (int k = 0; k < SCR_W; k++) pix({vb, 1'b0}, k == rc);
    for (int k = 0; k < hbl; k++) pix({vb, 1'b1}, 1'b0);
  endtask

  task automatic frame(input int rl, input int rc);
    for (int l = 0; l < SCR_H; l++) line(1'b0, (l == rl) ? rc : -1);
    repeat ($urandom_range(2, 3)) line(1'b1, -1);
  endtask

  // monitor: consumes expectations whenever the DUT presents an output on a cen cycle
  initial begin
    rom_exp_t e;
    tick_exp_t t;
    int s;
    forever begin
      @(posedge clk); #1;
      if (cen_i) begin
        mon_step++;
        if (pend_vld && mon_step == pend_step) begin
          chk("upd_pos_x", int'(pos_x_o), pend_px);
          chk("upd_pos_y", int'(pos_y_o), pend_py);
          pend_vld = 0;
        end
        while (rom_q.size() > 0 && rom_q[0].step < mon_step) begin
          e = rom_q.pop_front();
          checks++; errors++;
          $display("FAIL rom_en_missing actual=0 required=1 addr %0d (step %0d)", e.addr, e.step);
        end
        if (rom_en_o) begin
          if (rom_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL rom_en_unexpected actual=1 required=0 addr %0d (step %0d)", rom_addr_o, mon_step);
          end else begin
            e = rom_q.pop_front();
            chk("rom_en_step", mon_step, e.step);
            chk("rom_addr", int'(rom_addr_o), e.addr);
          end
        end
        while (pv_q.size() > 0 && pv_q[0] + ROM_LAT < mon_step) begin
          s = pv_q.pop_front();
          checks++; errors++;
          $display("FAIL pix_valid_missing actual=0 required=1 (due step %0d)", s + ROM_LAT);
        end
        if (pix_valid_o) begin
          if (pv_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL pix_valid_unexpected actual=1 required=0 (step %0d)", mon_step);
          end else begin
            s = pv_q.pop_front();
            chk("pix_valid_step", mon_step, s + ROM_LAT);
          end
        end
        while (tick_q.size() > 0 && tick_q[0].step < mon_step) begin
          t = tick_q.pop_front();
          checks++; errors++;
          $display("FAIL frame_tick_missing actual=0 required=1 (due step %0d)", t.step);
        end
        if (frame_tick_o) begin
          if (tick_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL frame_tick_unexpected actual=1 required=0 (step %0d)", mon_step);
          end else begin
            t = tick_q.pop_front();
            chk("frame_tick_step", mon_step, t.step);
            pend_vld  = 1;
            pend_step = mon_step + 1;
            pend_px   = t.px;
            pend_py   = t.py;
          end
        end
      end
    end
  end

  // driver: reset, raster frames in several cen patterns, mid-frame reset
  initial begin
    rst_i = 1'b1;
    cen_i = 1'b0;
    vh_blank_i = 2'b11;
    move_en_i = 1'b0;
    model_reset();
    cyc(1'b1, 1'b1, 2'b11);
    cyc(1'b1, 1'b1, 2'b11);
    @(posedge clk); #2;
    chk("rst_rom_addr", int'(rom_addr_o), 0);
    chk("rst_rom_en", int'(rom_en_o), 0);
    chk("rst_pix_valid", int'(pix_valid_o), 0);
    chk("rst_frame_tick", int'(frame_tick_o), 0);
    chk("rst_hcount", int'(hcount_o), 0);
    chk("rst_vcount", int'(vcount_o), 0);
    chk("rst_pos_x", int'(pos_x_o), PX0);
    chk("rst_pos_y", int'(pos_y_o), PY0);

    repeat (2) line(1'b1, -1);
    repeat (3) frame(-1, -1);
    chk("hold_pos_x", int'(pos_x_o), PX0);
    chk("hold_pos_y", int'(pos_y_o), PY0);

    move_en_i = 1'b1;
    repeat (6) frame(-1, -1);
    chk("edge_pos_x", int'(pos_x_o), LX);
    chk("bounce_pos_y", int'(pos_y_o), 10);
    repeat (12) frame(-1, -1);
    chk("origin_pos_x", int'(pos_x_o), 0);
    chk("edge_pos_y", int'(pos_y_o), LY);

    gap_mode = 1;
    for (int f = 0; f < 3; f++) begin
      move_en_i = 1'($urandom_range(0, 1));
      frame(-1, -1);
    end

    gap_mode = 2;
    move_en_i = 1'b1;
    frame(10, 15);
    frame(-1, -1);

    gap_mode = 0;
    frame(-1, -1);
    repeat (2) line(1'b1, -1);
    chk("rom_q_left", rom_q.size(), 0);
    chk("pv_q_left", pv_q.size(), 0);
    chk("tick_q_left", tick_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
